episode_history: RTL
====================

Name: episode_history

Overview:
- Parametrised successor to the theta-episode vote summariser.
- Accumulates per-gamma winner votes over a theta episode. At each theta_tick, commits argmax winner + strength into a DEPTH-deep ring history.
- Provides confidence and streak outputs for V3.3 top-down priming.
- Sits between the gamma-winner WTA stage and the score-bias logic.

Parameters:
- N_PAT, 6, number of candidate patterns/pairs.
- IDX_W, 3, winner index width; must satisfy 2^IDX_W >= N_PAT.
- VOTE_W, 4, per-pattern vote counter width; counters saturate.
- DEPTH, 4, history entries; power of two, >= 2.
- AGE_W, 2, log2(DEPTH).
- MIN_VOTES, 4, strength threshold for the confident flag.
- TIE_MODE, 0. 0 = lowest index wins ties. 1 = previous committed winner wins if it is among the tied maxima, else lowest index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gamma_tick  in  1  one-cycle pulse, gamma boundary
- theta_tick  in  1  one-cycle pulse, episode boundary
- win_valid  in  1  current_winner is meaningful this gamma
- current_winner  in  IDX_W  current gamma winner
- rd_age  in  AGE_W  history read index (0 = newest)
- ep_winner  out  IDX_W  newest committed winner
- ep_strength  out  VOTE_W  its vote count
- ep_valid  out  1  at least one episode committed
- ep_confident  out  1  ep_valid and ep_strength >= MIN_VOTES
- streak_len  out  AGE_W+1  consecutive confident episodes with same winner; saturates at DEPTH
- hist_winner  out  IDX_W  winner at rd_age
- hist_strength  out  VOTE_W  strength at rd_age
- hist_valid  out  1  entry at rd_age was written since reset
- gamma_cnt  out  VOTE_W  gamma votes accepted in current episode (saturating)
- overflow  out  1  sticky; any vote counter saturated since reset

Behaviour:
- Reset (rst high at posedge): all vote counters, history entries, their valid bits, write pointer, gamma_cnt, streak_len and overflow cleared. ep_winner = 0, ep_strength = 0, ep_valid = 0, ep_confident = 0. Reset overrides every tick that cycle; a mid-episode reset discards partial votes.
- Vote accept:
  - Condition: gamma_tick & win_valid & (current_winner < N_PAT).
  - Effect: vote[current_winner] increments, saturating at 2^VOTE_W-1; gamma_cnt increments, saturating.
  - Saturation attempt sets overflow (sticky).
  - Out-of-range index or win_valid = 0: no vote, gamma_cnt unchanged.
- Closing vote set: vote counters plus the same-cycle accepted vote. A gamma_tick coincident with theta_tick is counted into the closing episode, never dropped and never carried over.
- Argmax: combinational over the closing set, per TIE_MODE. In TIE_MODE 1 with ep_valid = 0, fall back to lowest index. All-zero votes give winner 0, strength 0.
- theta_tick commit, visible the next cycle (1-cycle latency):
  - history[wr_ptr] <= {winner, strength}, valid bit set; wr_ptr increments mod DEPTH (wrap overwrites oldest).
  - ep_winner/ep_strength updated; ep_valid <= 1.
  - Vote counters and gamma_cnt cleared.
- Empty episode (strength 0): still committed, with ep_confident = 0.
- streak_len at commit:
  - If the new entry is confident and winner == previous ep_winner and previous ep_confident: streak_len + 1, saturating at DEPTH.
  - Else if new entry is confident: 1.
  - Else: 0.
- ep_confident is combinational from registered ep_valid/ep_strength.
- History read: combinational from registered storage. Entry index = (wr_ptr - 1 - rd_age) mod DEPTH. hist_valid = 0 for entries not yet written.
- Same-cycle read of a committing entry returns the old contents.
- Back-to-back theta_ticks are legal: each commits an episode. The second has strength 0 unless a coincident vote arrives.

Decomposition:
- Package episode_pkg: default N_PAT/VOTE_W/DEPTH, TIE_LOWEST/TIE_STICKY mode constants, packed history-entry typedef {winner, strength}.
- Sub-module vote_argmax: parametrised N_PAT/VOTE_W/IDX_W combinational argmax with tie mode and prev-winner input. Reused by the V3.3 score-bias block.

Test Plan:
- Reset, then 8 gammas with winner 2, then theta_tick -> next cycle ep_winner = 2, ep_strength = 8, ep_valid = 1, ep_confident = 1, streak_len = 1, hist_valid(rd_age 0) = 1, hist_valid(rd_age 1) = 0.
- Votes 1,1,3,3 with TIE_MODE 0 -> winner 1, strength 2, confident = 0. With TIE_MODE 1 and previous winner 3 -> winner 3.
- Last gamma_tick (winner 4) coincident with theta_tick, votes otherwise 4:3 favouring 5 -> tie 4:4 resolves to 4 (mode 0). Next episode counters start at 0.
- 5 confident episodes, all winner 0 -> streak_len 1,2,3,4,4. Then a winner-5 confident episode -> 1. Rd_age 0..3 reads 5,0,0,0.
- 20 gammas with winner 1, VOTE_W = 4 -> strength 15, overflow = 1 and stays set across theta_tick. win_valid = 0 or index 6/7 gammas -> no count change.
- Assert rst mid-episode after 3 votes, then theta_tick -> ep_valid = 0 until the commit, then strength 0, hist_valid = 1 only at rd_age 0.

Source files
------------

// File: rtl/episode_pkg.sv
// Shared constants and types for the theta-episode history block and its
// argmax helper.
package episode_pkg;
    localparam int N_PAT_DEF  = 6;
    localparam int IDX_W_DEF  = 3;
    localparam int VOTE_W_DEF = 4;
    localparam int DEPTH_DEF  = 4;

    localparam int TIE_LOWEST = 0;
    localparam int TIE_STICKY = 1;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]  winner;
        logic [VOTE_W_DEF-1:0] strength;
    } hist_entry_t;
endpackage

// File: rtl/vote_argmax.sv
// Combinational argmax over per-pattern vote counts.
// Ties go to the lowest index, or to prev_winner in sticky mode.
module vote_argmax
    import episode_pkg::*;
#(
    parameter int N_PAT    = N_PAT_DEF,
    parameter int VOTE_W   = VOTE_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int TIE_MODE = TIE_LOWEST
) (
    input  logic [N_PAT-1:0][VOTE_W-1:0] votes,
    input  logic [IDX_W-1:0]             prev_winner,
    input  logic                         prev_valid,
    output logic [IDX_W-1:0]             winner,
    output logic [VOTE_W-1:0]            strength
);
    logic [IDX_W-1:0]  best_w;
    logic [VOTE_W-1:0] best_s;

    always_comb begin
        best_w = '0;
        best_s = votes[0];
        // Strict greater-than keeps the lowest index among equal maxima.
        for (int i = 1; i < N_PAT; i++) begin
            if (votes[i] > best_s) begin
                best_w = IDX_W'(i);
                best_s = votes[i];
            end
        end
        if (TIE_MODE == TIE_STICKY && prev_valid) begin
            for (int i = 0; i < N_PAT; i++) begin
                if (prev_winner == IDX_W'(i) && votes[i] == best_s)
                    best_w = IDX_W'(i);
            end
        end
        winner   = best_w;
        strength = best_s;
    end
endmodule

// File: rtl/episode_history.sv
// Per-theta-episode vote summariser: accumulates gamma winner votes, commits
// the argmax into a ring history, and reports confidence and streak length.
module episode_history
    import episode_pkg::*;
#(
    parameter int N_PAT     = N_PAT_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int VOTE_W    = VOTE_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AGE_W     = 2,
    parameter int MIN_VOTES = 4,
    parameter int TIE_MODE  = TIE_LOWEST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gamma_tick,
    input  logic              theta_tick,
    input  logic              win_valid,
    input  logic [IDX_W-1:0]  current_winner,
    input  logic [AGE_W-1:0]  rd_age,
    output logic [IDX_W-1:0]  ep_winner,
    output logic [VOTE_W-1:0] ep_strength,
    output logic              ep_valid,
    output logic              ep_confident,
    output logic [AGE_W:0]    streak_len,
    output logic [IDX_W-1:0]  hist_winner,
    output logic [VOTE_W-1:0] hist_strength,
    output logic              hist_valid,
    output logic [VOTE_W-1:0] gamma_cnt,
    output logic              overflow
);
    typedef struct packed {
        logic [IDX_W-1:0]  winner;
        logic [VOTE_W-1:0] strength;
    } entry_t;

    localparam logic [VOTE_W-1:0] VOTE_MAX = '1;

    logic [N_PAT-1:0][VOTE_W-1:0] votes, close_votes;
    entry_t                       hist [DEPTH];
    logic [DEPTH-1:0]             hist_vld;
    logic [AGE_W-1:0]             wr_ptr, rd_idx;
    logic                         accept, sat_hit, new_conf;
    logic [IDX_W-1:0]             win_w;
    logic [VOTE_W-1:0]            win_s;
    logic [AGE_W:0]               streak_nxt;

    assign accept = gamma_tick & win_valid &
                    ({1'b0, current_winner} < (IDX_W+1)'(N_PAT));

    // Closing set includes this cycle's vote so a coincident gamma lands in
    // the episode being committed.
    always_comb begin
        close_votes = votes;
        sat_hit     = 1'b0;
        if (accept) begin
            for (int i = 0; i < N_PAT; i++) begin
                if (current_winner == IDX_W'(i)) begin
                    if (votes[i] == VOTE_MAX) sat_hit = 1'b1;
                    else close_votes[i] = votes[i] + VOTE_W'(1);
                end
            end
        end
    end

    vote_argmax #(
        .N_PAT(N_PAT), .VOTE_W(VOTE_W), .IDX_W(IDX_W), .TIE_MODE(TIE_MODE)
    ) u_argmax (
        .votes(close_votes),
        .prev_winner(ep_winner),
        .prev_valid(ep_valid),
        .winner(win_w),
        .strength(win_s)
    );

    assign new_conf = win_s >= VOTE_W'(MIN_VOTES);

    always_comb begin
        streak_nxt = '0;
        if (new_conf && ep_confident && win_w == ep_winner)
            streak_nxt = (streak_len == (AGE_W+1)'(DEPTH)) ? streak_len
                                                           : streak_len + (AGE_W+1)'(1);
        else if (new_conf)
            streak_nxt = (AGE_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            votes       <= '0;
            gamma_cnt   <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            hist_vld    <= '0;
            ep_winner   <= '0;
            ep_strength <= '0;
            ep_valid    <= 1'b0;
            streak_len  <= '0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else begin
            if (sat_hit) overflow <= 1'b1;
            if (theta_tick) begin
                hist[wr_ptr]     <= '{winner: win_w, strength: win_s};
                hist_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + AGE_W'(1);
                ep_winner        <= win_w;
                ep_strength      <= win_s;
                ep_valid         <= 1'b1;
                streak_len       <= streak_nxt;
                votes            <= '0;
                gamma_cnt        <= '0;
            end else begin
                votes <= close_votes;
                if (accept && gamma_cnt != VOTE_MAX) gamma_cnt <= gamma_cnt + VOTE_W'(1);
            end
        end
    end

    assign ep_confident  = ep_valid && (ep_strength >= VOTE_W'(MIN_VOTES));
    assign rd_idx        = wr_ptr - AGE_W'(1) - rd_age;
    assign hist_winner   = hist[rd_idx].winner;
    assign hist_strength = hist[rd_idx].strength;
    assign hist_valid    = hist_vld[rd_idx];
endmodule
